// File: rtl/phy_pkg.sv
// Shared PHY definitions: fill bytes, frame geometry and the link FSM encoding.
package phy_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic {
    StSync,
    StRun
  } phy_state_e;

  // A fill frame is the same byte repeated across all byte positions.
  function automatic logic [FRAME_BITS-1:0] fill_word(input logic [7:0] b);
    return {(FRAME_BITS / 8){b}};
  endfunction

endpackage

// File: rtl/phy_tx_lane_ser.sv
// One transmit lane: a single-word holding slot feeding a 32-bit MSB-first shift register.
module phy_tx_lane_ser
  import phy_pkg::*;
#(
  parameter logic [7:0] COM_BYTE = COM,
  parameter logic [7:0] IDL_BYTE = IDL
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,     // frame boundary: shift register takes a new word
  input  logic                  i_sync,     // link not up yet: load COM fill
  input  logic                  i_wr_en,    // word accepted for this lane this cycle
  input  logic [FRAME_BITS-1:0] i_wr_data,
  output logic                  o_slot_full,
  output logic                  o_bit
);

  logic [FRAME_BITS-1:0] r_slot;
  logic                  r_slot_full;
  logic [FRAME_BITS-1:0] r_shreg;

  logic [FRAME_BITS-1:0] w_load_word;
  logic                  w_bypass;
  logic                  w_slot_take;

  // A word accepted into an empty slot on the boundary edge goes straight into the
  // shift register, so it still leaves in the very next frame.
  assign w_bypass    = i_load & ~i_sync & ~r_slot_full & i_wr_en;
  assign w_slot_take = i_load & ~i_sync & r_slot_full;

  // Select what the shift register loads at the frame boundary.
  always_comb begin
    w_load_word = fill_word(IDL_BYTE);
    if (i_sync) begin
      w_load_word = fill_word(COM_BYTE);
    end else if (r_slot_full) begin
      w_load_word = r_slot;
    end else if (i_wr_en) begin
      w_load_word = i_wr_data;
    end
  end

  // Slot fill/drain; a write on the draining edge refills it so it stays full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot      <= '0;
      r_slot_full <= 1'b0;
    end else if (i_wr_en && !w_bypass) begin
      r_slot      <= i_wr_data;
      r_slot_full <= 1'b1;
    end else if (w_slot_take) begin
      r_slot_full <= 1'b0;
    end
  end

  // Shift register: load on the boundary, otherwise shift left one bit per clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= w_load_word;
    end else begin
      r_shreg <= {r_shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign o_slot_full = r_slot_full;
  assign o_bit       = r_shreg[FRAME_BITS-1];

endmodule

// File: rtl/phy_tx.sv
// Transmit PHY: stripes handshaked 32-bit words alternately onto two serial lanes,
// with COM alignment frames after reset and IDL fill when a lane has nothing to send.
module phy_tx
  import phy_pkg::*;
#(
  parameter int unsigned SYNC_WORDS = 4,
  parameter logic [7:0]  COM_BYTE   = COM,
  parameter logic [7:0]  IDL_BYTE   = IDL
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out_0,
  output logic        data_out_1
);

  localparam int unsigned SYNC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [SYNC_W-1:0] r_sync_cnt;
  phy_state_e        r_state;
  phy_state_e        w_state_next;
  logic              r_ptr;

  logic w_boundary;
  logic w_sync_last;
  logic w_sync;
  logic w_ready;
  logic w_xfer;
  logic w_full_0;
  logic w_full_1;
  logic w_full_sel;

  assign w_boundary  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_sync_last = (r_sync_cnt == SYNC_W'(SYNC_WORDS - 1));
  assign w_full_sel  = r_ptr ? w_full_1 : w_full_0;
  assign w_xfer      = valid_in & w_ready;

  // Free-running bit position within the frame.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Count COM frames loaded while in SYNC.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_sync_cnt <= '0;
    end else if (r_state == StSync && w_boundary) begin
      r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: leave SYNC once the last COM frame has been loaded.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StSync:  if (w_boundary && w_sync_last) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StSync;
    endcase
  end

  // FSM outputs: the target slot can take a word if empty, or on the edge where it drains.
  always_comb begin
    w_sync  = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      StSync:  w_sync = 1'b1;
      StRun:   w_ready = ~w_full_sel | w_boundary;
      default: w_sync = 1'b1;
    endcase
  end

  // Stripe pointer toggles on every accepted word.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_xfer) begin
      r_ptr <= ~r_ptr;
    end
  end

  phy_tx_lane_ser #(
    .COM_BYTE (COM_BYTE),
    .IDL_BYTE (IDL_BYTE)
  ) u_lane_0 (
    .i_clk       (clk_32f),
    .i_rst       (reset),
    .i_load      (w_boundary),
    .i_sync      (w_sync),
    .i_wr_en     (w_xfer & ~r_ptr),
    .i_wr_data   (data_in),
    .o_slot_full (w_full_0),
    .o_bit       (data_out_0)
  );

  phy_tx_lane_ser #(
    .COM_BYTE (COM_BYTE),
    .IDL_BYTE (IDL_BYTE)
  ) u_lane_1 (
    .i_clk       (clk_32f),
    .i_rst       (reset),
    .i_load      (w_boundary),
    .i_sync      (w_sync),
    .i_wr_en     (w_xfer & r_ptr),
    .i_wr_data   (data_in),
    .o_slot_full (w_full_1),
    .o_bit       (data_out_1)
  );

  assign ready_out = w_ready;

endmodule
